mips_bus_arbiter: RTL
=====================

# mips_bus_arbiter

Two-master arbiter that shares the single memory bus (address/read/write/byte_en/writedata/readdata/waitrequest, waitrequest-stalled) between the `mips_cpu_bus` master port (M0) and a second bus master such as a loader or debug port (M1). It sits between the masters and `mips_memory`, grants the bus to one master per transfer using round-robin arbitration, and passes the granted master's command through to the memory. It also keeps a saturating completed-transfer count for each master.

## Interface
Parameters:
- CNT_WIDTH, 16, width of each per-master completed-transfer counter

Ports:
- clk  in  1  single system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- m0_address, m1_address  in  32  master byte addresses
- m0_read, m1_read  in  1  read request; held high until the master's waitrequest is low
- m0_write, m1_write  in  1  write request; held high until the master's waitrequest is low
- m0_byte_en, m1_byte_en  in  4  byte enables
- m0_writedata, m1_writedata  in  32  write data
- m0_readdata, m1_readdata  out  32  read data, always equal to s_readdata
- m0_waitrequest, m1_waitrequest  out  1  stall signal to each master
- s_address  out  32  address to memory
- s_read, s_write  out  1  read and write commands to memory
- s_byte_en  out  4  byte enables to memory
- s_writedata  out  32  write data to memory
- s_readdata  in  32  read data from memory
- s_waitrequest  in  1  stall signal from memory
- m0_xfers, m1_xfers  out  CNT_WIDTH  number of completed transfers per master, saturating

## Operation
- Request definition: reqN = mN_read | mN_write.
- States:
  - IDLE: no owner.
  - GNT0: M0 owns the bus.
  - GNT1: M1 owns the bus.
- Register last_gnt holds the most recently granted master. It resets to 1, so M0 wins the first contested arbitration.
- Arbitration in IDLE, taking effect at the next edge:
  - Only one master requesting: grant that master.
  - Both requesting: grant the master that is not last_gnt.
  - Neither requesting: stay in IDLE.
- Datapath in GNTn:
  - s_address, s_read, s_write, s_byte_en and s_writedata are a combinational pass-through of master n.
  - mn_waitrequest = s_waitrequest.
- Datapath in IDLE: all s_* command outputs are 0.
- Non-owner: the waitrequest of any master that does not own the bus is 1.
- Completion: owner n is granted, (s_read | s_write) = 1 and s_waitrequest = 0 in the same cycle.
- At the completion edge:
  - mN_xfers increments by 1 and saturates at 2^CNT_WIDTH-1.
  - last_gnt becomes n.
  - If the other master is requesting, the next state is that master's GNT. This gives a back-to-back handover with no bubble.
  - Otherwise the next state is IDLE, and the owner re-arbitrates. A master issuing consecutive transfers therefore sees one idle cycle between them.
- Request drop: if the owner drops read and write before completion (protocol violation), the next state is IDLE, no count is recorded, and last_gnt is unchanged.
- Read and write asserted together are passed through as-is; the arbiter does not check them.
- Reset: rst_n low at any time, including mid-transfer, takes effect immediately and asynchronously:
  - state = IDLE, last_gnt = 1, both counters = 0;
  - all s_* command outputs = 0;
  - m0_waitrequest = m1_waitrequest = 1.
  - Any in-flight transfer is abandoned.

## Timing
- Grant latency: a request first seen high in cycle k, with the arbiter in IDLE, is driven on s_* in cycle k+1.
- Minimum transfer duration: with s_waitrequest = 0, a master's waitrequest drops low in cycle k+1, i.e. 2 cycles from request to accept.
- Each cycle that s_waitrequest = 1 adds one cycle.
- Read data: m*_readdata is valid in the completion cycle only.
- Counters: mN_xfers updates on the edge that ends the completion cycle and is visible in the following cycle.
- Outputs: all outputs are combinational from registered state plus the pass-through inputs. There are no registered data paths.

## Test plan
- Single M0 read: M0 reads 0x0000_0010, memory returns 0xDEAD_BEEF with s_waitrequest = 0 -> s_read is high in cycle 2 only, m0_readdata = 0xDEAD_BEEF with m0_waitrequest = 0 in cycle 2, m0_xfers = 1, m1_waitrequest = 1 throughout.
- Simultaneous requests after reset: M0 writes 0x1111_1111 to 0x100 and M1 writes 0x2222_2222 to 0x200 in the same cycle -> M0 is served first, then M1 is granted back-to-back on the next cycle, memory sees both writes in that order, and both counters = 1.
- Memory stall: M1 reads while s_waitrequest = 1 for 3 cycles -> m1_waitrequest is high for 3 cycles, s_address is stable at M1's address, completion comes on the 4th granted cycle, and M0's request raised during the stall is granted in the next cycle.
- Round-robin fairness: both masters hold requests continuously for 10 transfers -> grants alternate M0, M1, M0, … and each counter ends at 5.
- Reset mid-transfer: rst_n is pulsed low while in GNT1 with s_waitrequest = 1 -> s_read = s_write = 0 and both waitrequests = 1 immediately, counters = 0, and after release M0 wins a contested request.
- Counter saturation: with CNT_WIDTH = 2, run 5 M0 transfers -> m0_xfers reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/mips_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mips_bus_arbiter
//
// Shares one waitrequest-stalled memory bus between two masters: M0 (the
// mips_cpu_bus master port) and M1 (a loader or debug port). One master owns
// the bus per transfer, and round-robin arbitration picks the owner when both
// request. The owner's command is passed combinationally to the memory. Each
// master has a saturating count of completed transfers.
//
// Ports
//   clk, rst_n            system clock, asynchronous active-low reset
//   m{0,1}_address/read/write/byte_en/writedata
//                         master command inputs
//   m{0,1}_readdata       read data to each master (always s_readdata)
//   m{0,1}_waitrequest    stall to each master (1 whenever it is not the owner)
//   s_address/read/write/byte_en/writedata
//                         command to memory (all zero when no owner)
//   s_readdata, s_waitrequest
//                         response from memory
//   m{0,1}_xfers          saturating completed-transfer counters
// -----------------------------------------------------------------------------
module mips_bus_arbiter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          m0_address,
  input  logic                 m0_read,
  input  logic                 m0_write,
  input  logic [3:0]           m0_byte_en,
  input  logic [31:0]          m0_writedata,
  output logic [31:0]          m0_readdata,
  output logic                 m0_waitrequest,
  input  logic [31:0]          m1_address,
  input  logic                 m1_read,
  input  logic                 m1_write,
  input  logic [3:0]           m1_byte_en,
  input  logic [31:0]          m1_writedata,
  output logic [31:0]          m1_readdata,
  output logic                 m1_waitrequest,
  output logic [31:0]          s_address,
  output logic                 s_read,
  output logic                 s_write,
  output logic [3:0]           s_byte_en,
  output logic [31:0]          s_writedata,
  input  logic [31:0]          s_readdata,
  input  logic                 s_waitrequest,
  output logic [CNT_WIDTH-1:0] m0_xfers,
  output logic [CNT_WIDTH-1:0] m1_xfers
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 last_gnt_q, last_gnt_d;
  logic [CNT_WIDTH-1:0] m0_xfers_q, m0_xfers_d;
  logic [CNT_WIDTH-1:0] m1_xfers_q, m1_xfers_d;
  logic                 req0, req1;
  logic                 inc0, inc1;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its inputs regardless of statement order.
  // NOTE: the counters are ordinary flops, not memory, so they are reset with
  // the rest of the state; a reset mid-transfer clears them immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;  // M0 wins the first contested arbitration
      m0_xfers_q <= '0;
      m1_xfers_q <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      m0_xfers_q <= m0_xfers_d;
      m1_xfers_q <= m1_xfers_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // While granted, s_read | s_write is exactly the owner's request, so a
  // completion is "owner still requesting and memory not stalling".
  // NOTE: every signal assigned here gets a default first so no path through
  // the case leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    inc0       = 1'b0;
    inc1       = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 && req1) state_d = last_gnt_q ? GNT0 : GNT1;
        else if (req0)    state_d = GNT0;
        else if (req1)    state_d = GNT1;
      end
      GNT0: begin
        if (!req0) begin
          state_d = IDLE;  // request dropped early: no count, no rotation
        end else if (!s_waitrequest) begin
          inc0       = 1'b1;
          last_gnt_d = 1'b0;
          state_d    = req1 ? GNT1 : IDLE;  // back-to-back handover to M1
        end
      end
      GNT1: begin
        if (!req1) begin
          state_d = IDLE;
        end else if (!s_waitrequest) begin
          inc1       = 1'b1;
          last_gnt_d = 1'b1;
          state_d    = req0 ? GNT0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Saturating counters: hold at all-ones instead of wrapping.
  always_comb begin
    m0_xfers_d = m0_xfers_q;
    m1_xfers_d = m1_xfers_q;
    if (inc0 && (m0_xfers_q != '1)) m0_xfers_d = m0_xfers_q + 1'b1;
    if (inc1 && (m1_xfers_q != '1)) m1_xfers_d = m1_xfers_q + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Output logic: pass-through of the owner, idle bus otherwise
  // ---------------------------------------------------------------------------
  always_comb begin
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_byte_en      = '0;
    s_writedata    = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    case (state_q)
      GNT0: begin
        s_address      = m0_address;
        s_read         = m0_read;
        s_write        = m0_write;
        s_byte_en      = m0_byte_en;
        s_writedata    = m0_writedata;
        m0_waitrequest = s_waitrequest;
      end
      GNT1: begin
        s_address      = m1_address;
        s_read         = m1_read;
        s_write        = m1_write;
        s_byte_en      = m1_byte_en;
        s_writedata    = m1_writedata;
        m1_waitrequest = s_waitrequest;
      end
      default: ;
    endcase
  end

  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;
  assign m0_xfers    = m0_xfers_q;
  assign m1_xfers    = m1_xfers_q;

endmodule
